// File: rtl/motion_tracker.sv
// Motor-action sequencer for the wall-following robot: turns front/rotate commands into timed
// forward moves or clockwise turns, drives the motors and keeps the robot pose up to date.
module motion_tracker #(
    parameter int W           = 8,
    parameter int STEP_CYCLES = 4,
    parameter int TURN_CYCLES = 2,
    parameter int X0          = 0,
    parameter int Y0          = 0,
    parameter int DIR0        = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         front,
    input  logic         rotate,
    output logic [1:0]   drive_l,
    output logic [1:0]   drive_r,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic [1:0]   heading,
    output logic [15:0]  move_count
);

    localparam int MAXC = (STEP_CYCLES > TURN_CYCLES) ? STEP_CYCLES : TURN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [1:0] DRV_STOP = 2'b00;
    localparam logic [1:0] DRV_FWD  = 2'b01;
    localparam logic [1:0] DRV_REV  = 2'b10;

    typedef enum logic [1:0] {IDLE, MOVING, TURNING} state_t;

    state_t         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [1:0]     r_driveL, w_driveL;
    logic [1:0]     r_driveR, w_driveR;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic [W-1:0]   r_x, w_x;
    logic [W-1:0]   r_y, w_y;
    logic [1:0]     r_heading, w_heading;
    logic [15:0]    r_moveCount, w_moveCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_driveL    <= DRV_STOP;
            r_driveR    <= DRV_STOP;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_x         <= W'(X0);
            r_y         <= W'(Y0);
            r_heading   <= 2'(DIR0);
            r_moveCount <= '0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_driveL    <= w_driveL;
            r_driveR    <= w_driveR;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_x         <= w_x;
            r_y         <= w_y;
            r_heading   <= w_heading;
            r_moveCount <= w_moveCount;
        end
    end

    // Every output is computed here one cycle ahead, so the pose update and done pulse share the closing edge.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_driveL    = r_driveL;
        w_driveR    = r_driveR;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_x         = r_x;
        w_y         = r_y;
        w_heading   = r_heading;
        w_moveCount = r_moveCount;

        case (r_state)
            IDLE: begin
                w_driveL = DRV_STOP;
                w_driveR = DRV_STOP;
                w_busy   = 1'b0;
                if (rotate) begin
                    w_state  = TURNING;
                    w_cnt    = CW'(TURN_CYCLES - 1);
                    w_driveL = DRV_FWD;
                    w_driveR = DRV_REV;
                    w_busy   = 1'b1;
                end else if (front) begin
                    w_state  = MOVING;
                    w_cnt    = CW'(STEP_CYCLES - 1);
                    w_driveL = DRV_FWD;
                    w_driveR = DRV_FWD;
                    w_busy   = 1'b1;
                end
            end

            MOVING: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - CW'(1);
                end else begin
                    w_state  = IDLE;
                    w_driveL = DRV_STOP;
                    w_driveR = DRV_STOP;
                    w_busy   = 1'b0;
                    w_done   = 1'b1;
                    case (r_heading)
                        2'd0:    w_y = r_y + W'(1);
                        2'd1:    w_x = r_x + W'(1);
                        2'd2:    w_y = r_y - W'(1);
                        default: w_x = r_x - W'(1);
                    endcase
                    if (r_moveCount != 16'hFFFF) begin
                        w_moveCount = r_moveCount + 16'd1;
                    end
                end
            end

            TURNING: begin
                if (r_cnt != '0) begin
                    w_cnt = r_cnt - CW'(1);
                end else begin
                    w_state   = IDLE;
                    w_driveL  = DRV_STOP;
                    w_driveR  = DRV_STOP;
                    w_busy    = 1'b0;
                    w_done    = 1'b1;
                    w_heading = r_heading + 2'd1;
                end
            end

            default: begin
                w_state  = IDLE;
                w_driveL = DRV_STOP;
                w_driveR = DRV_STOP;
                w_busy   = 1'b0;
            end
        endcase
    end

    assign drive_l    = r_driveL;
    assign drive_r    = r_driveR;
    assign busy       = r_busy;
    assign done       = r_done;
    assign x          = r_x;
    assign y          = r_y;
    assign heading    = r_heading;
    assign move_count = r_moveCount;

endmodule

// File: tb/tb_motion_tracker.sv
// Self-checking bench for motion_tracker: a pose model pushes expected results into a scoreboard
// queue when each command is driven, and they are popped and compared on the done cycle.
module tb_motion_tracker;

    logic        clk;
    logic        rst_n;
    logic        front;
    logic        rotate;
    logic [1:0]  drive_l;
    logic [1:0]  drive_r;
    logic        busy;
    logic        done;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [1:0]  heading;
    logic [15:0] move_count;

    typedef struct packed {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [1:0]  h;
        logic [15:0] mc;
    } pose_t;

    pose_t       sbq[$];
    logic [7:0]  mx;
    logic [7:0]  my;
    logic [1:0]  mh;
    logic [15:0] mc;
    int          vectors;
    int          miscompares;

    motion_tracker #(
        .W(8), .STEP_CYCLES(4), .TURN_CYCLES(2), .X0(0), .Y0(0), .DIR0(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .front(front), .rotate(rotate),
        .drive_l(drive_l), .drive_r(drive_r), .busy(busy), .done(done),
        .x(x), .y(y), .heading(heading), .move_count(move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " drive_l"}, 32'(drive_l), 32'd0);
        checkOutput({tag, " drive_r"}, 32'(drive_r), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " x"}, 32'(x), 32'd0);
        checkOutput({tag, " y"}, 32'(y), 32'd0);
        checkOutput({tag, " heading"}, 32'(heading), 32'd0);
        checkOutput({tag, " move_count"}, 32'(move_count), 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic applyStimulus(input bit isTurn, input bit f, input bit r,
                                 input bit hold, input bit toggle, input string tag);
        int    len;
        pose_t e;
        front  = f;
        rotate = r;
        if (isTurn) begin
            mh = mh + 2'd1;
        end else begin
            case (mh)
                2'd0:    my = my + 8'd1;
                2'd1:    mx = mx + 8'd1;
                2'd2:    my = my - 8'd1;
                default: mx = mx - 8'd1;
            endcase
            if (mc != 16'hFFFF) mc = mc + 16'd1;
        end
        sbq.push_back('{x: mx, y: my, h: mh, mc: mc});
        @(negedge clk);
        if (!hold) begin
            front  = 1'b0;
            rotate = 1'b0;
        end
        len = isTurn ? 2 : 4;
        for (int i = 0; i < len; i++) begin
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            checkOutput({tag, " done-while-busy"}, 32'(done), 32'd0);
            checkOutput({tag, " drive_l"}, 32'(drive_l), 32'd1);
            checkOutput({tag, " drive_r"}, 32'(drive_r), isTurn ? 32'd2 : 32'd1);
            if (toggle) front = ~front;
            @(negedge clk);
        end
        if (toggle) front = 1'b0;
        checkOutput({tag, " done"}, 32'(done), 32'd1);
        checkOutput({tag, " busy-at-done"}, 32'(busy), 32'd0);
        checkOutput({tag, " drive_l-stop"}, 32'(drive_l), 32'd0);
        checkOutput({tag, " drive_r-stop"}, 32'(drive_r), 32'd0);
        if (sbq.size() == 0) begin
            checkOutput({tag, " scoreboard-empty"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            checkOutput({tag, " x"}, 32'(x), 32'(e.x));
            checkOutput({tag, " y"}, 32'(y), 32'(e.y));
            checkOutput({tag, " heading"}, 32'(heading), 32'(e.h));
            checkOutput({tag, " move_count"}, 32'(move_count), 32'(e.mc));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mx = 8'd0; my = 8'd0; mh = 2'd0; mc = 16'd0;

        // Reset held with a pending forward request must keep everything stopped.
        rst_n  = 1'b0;
        front  = 1'b1;
        rotate = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset");
        checkOutput("reset done", 32'(done), 32'd0);
        front = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle busy", 32'(busy), 32'd0);
        checkOutput("idle done", 32'(done), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "moveN");
        @(negedge clk);
        checkOutput("moveN done-pulse-ends", 32'(done), 32'd0);

        // Rotate held across four turns: back-to-back acceptance on each done cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "turn1");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "turn2");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "turn3");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "turn4");
        rotate = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "toW1");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "toW2");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "toW3");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wrapX255");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "wrapX254");

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "priority");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "ignoreToggle");
        @(negedge clk);
        checkOutput("ignore busy-after", 32'(busy), 32'd0);
        checkOutput("ignore move_count-after", 32'(move_count), 32'(mc));

        // Abort a move two edges in (cnt=2).
        front = 1'b1;
        @(negedge clk);
        front = 1'b0;
        checkOutput("abort started", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkReset("abort");
        @(negedge clk);
        checkOutput("abort done-in-reset", 32'(done), 32'd0);
        rst_n = 1'b1;
        mx = 8'd0; my = 8'd0; mh = 2'd0; mc = 16'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("abort no-done", 32'(done), 32'd0);
            checkOutput("abort no-busy", 32'(busy), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "postAbortMove");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
